vga_scan_engine: RTL and testbench
==================================

# vga_scan_engine

Parametrised VGA scan engine: generates horizontal/vertical timing, issues framebuffer read requests, absorbs a configurable memory read latency, and drives sync/blank/RGB pins with all signals mutually aligned. It replaces the fixed 640x480 controller at the top level, sitting between the pixel clock domain's framebuffer and the VGA pins. It adds resolution and porch parameters, integer pixel replication, built-in test patterns, and frame-boundary enable/disable.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- SCALE_LOG2, 0, pixel replication factor 2^SCALE_LOG2 in both axes (0..2)
- FB_LATENCY, 0, framebuffer read latency in clocks (0 = combinational read)
- COLOR_W, 8, bits per colour channel
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  scan enable, sampled only at frame boundary
- pattern_sel  in  2  0 framebuffer, 1 colour bars, 2 checkerboard, 3 solid white
- fb_rd_en  out  1  framebuffer read strobe
- fb_x  out  10  framebuffer column (h_cnt >> SCALE_LOG2)
- fb_y  out  9  framebuffer row (v_cnt >> SCALE_LOG2)
- fb_rdata  in  3*COLOR_W  {R,G,B}, valid FB_LATENCY clocks after fb_rd_en
- hsync, vsync  out  1  sync pins
- blank_n  out  1  high during visible pixels
- vga_r, vga_g, vga_b  out  COLOR_W  colour pins, zero when blank_n low
- sof  out  1  one-clock pulse aligned with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; line order active, FP, sync, BP.
- h_cnt increments each clock; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps at V_TOTAL-1 on the same clock h_cnt wraps.
- Stage-0 decode from counters: active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise on v_cnt.
- fb_rd_en = active && pattern_sel==0 && running; fb_x/fb_y combinational from counters, zero when not active.
- Run state: IDLE (counters held at 0,0, no requests, outputs blank, syncs inactive) and RUN. IDLE->RUN when en=1 (next clock counters start). RUN->IDLE only on the wrap from (H_TOTAL-1, V_TOTAL-1) with en=0; en deassertion mid-frame completes the frame.
- Test patterns from stage-0 counters: bars = 8 equal bands by h_cnt*8/H_ACTIVE, colours white,yellow,cyan,green,magenta,red,blue,black (channel full-scale or 0); checker = white when h_cnt[3]^v_cnt[3] else black.
- Delay line: active, hs, vs, sof-flag, pattern colour, pattern_sel delayed FB_LATENCY clocks, then all registered once together with selected colour (fb_rdata or pattern). pattern_sel change mid-frame takes effect per pixel, no glitch beyond that pixel.

## Timing
- Pin latency: outputs reflect counter state of FB_LATENCY+1 clocks earlier; fb_rdata sampled exactly FB_LATENCY clocks after its request.
- Reset (rst low, asynchronous): counters 0, state IDLE, delay line cleared, hsync=vsync=~SYNC_POL, blank_n=0, RGB=0, sof=0, fb_rd_en=0. Release mid-frame restarts at (0,0) of a new frame.
- First sof after IDLE->RUN: FB_LATENCY+1 clocks after counters leave IDLE at (0,0).
- Frame period exactly H_TOTAL*V_TOTAL clocks; hsync pulse exactly H_SYNC clocks; vsync exactly V_SYNC*H_TOTAL clocks, edges coincident with h_cnt=0.
- Each fb address held for 2^SCALE_LOG2 consecutive pixels and lines.

## Test plan
- Defaults, en=1, FB_LATENCY=0, fb_rdata=model of x,y: hsync low 96 clocks per 800, vsync low 1600 clocks per 420000, blank_n high 640x480 per frame, RGB matches model at every pixel.
- FB_LATENCY=2, memory model with 2-cycle pipeline: pixel (0,0) colour appears with sof 3 clocks after counter (0,0); no pixel offset across line wraps.
- SCALE_LOG2=1: fb_x sequence 0,0,1,1,...319,319; fb_y repeats each row twice; fb_y max 239.
- pattern_sel=1: vga_r/g/b per 80-pixel band match bar table; pattern_sel=2 produces 8x8 checker; fb_rd_en stays 0.
- en dropped at mid-frame (v_cnt=200): frame completes, counters hold (0,0), blank_n=0, syncs inactive; en re-asserted -> sof after FB_LATENCY+1 clocks.
- rst asserted at h_cnt=500,v_cnt=300: all outputs at reset values immediately (no clock); after release scan restarts from (0,0).

Source files
------------

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised VGA timing, framebuffer fetch, test patterns.
// In: clk, rst (async low), en, pattern_sel, fb_rdata. Out: fb_rd_en/x/y, pins.
module vga_scan_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SCALE_LOG2 = 0,
  parameter int FB_LATENCY = 0,
  parameter int COLOR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           pattern_sel,
  output logic                 fb_rd_en,
  output logic [9:0]           fb_x,
  output logic [8:0]           fb_y,
  input  logic [3*COLOR_W-1:0] fb_rdata,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL + 1);
  localparam int VW  = $clog2(V_TOTAL + 1);
  localparam int HW3 = HW + 3;
  localparam int CW3 = 3 * COLOR_W;
  localparam int DW  = 6 + CW3;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HA_C   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VA_C   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW3-1:0] HA8   = HW3'(H_ACTIVE);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e          st_q, st_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= IDLE;
      h_q  <= '0;
      v_q  <= '0;
    end else begin
      st_q <= st_d;
      h_q  <= h_d;
      v_q  <= v_d;
    end
  end

  // Stop only on the last pixel of a frame so a frame is never cut short.
  always_comb begin
    st_d = st_q;
    h_d  = h_q;
    v_d  = v_q;
    case (st_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) st_d = RUN;
      end
      default: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!en) st_d = IDLE;
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
    endcase
  end

  logic            run, act0, hs0, vs0, sof0;
  logic [HW3-1:0]  h8;
  logic [2:0]      bar_idx, bar_m, pat_m;
  logic [CW3-1:0]  pat0;
  logic [HW-1:0]   hx;
  logic [VW-1:0]   vy;

  always_comb begin
    run  = (st_q == RUN);
    act0 = run && (h_q < HA_C) && (v_q < VA_C);
    hs0  = run && (h_q >= HS_B) && (h_q < HS_E);
    vs0  = run && (v_q >= VS_B) && (v_q < VS_E);
    sof0 = run && (h_q == '0) && (v_q == '0);
  end

  assign h8      = {h_q, 3'b000};
  assign bar_idx = 3'(h8 / HA8);

  // Bar mask is {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar_m = 3'b000;
    case (bar_idx)
      3'd0:    bar_m = 3'b111;
      3'd1:    bar_m = 3'b110;
      3'd2:    bar_m = 3'b011;
      3'd3:    bar_m = 3'b010;
      3'd4:    bar_m = 3'b101;
      3'd5:    bar_m = 3'b100;
      3'd6:    bar_m = 3'b001;
      default: bar_m = 3'b000;
    endcase
  end

  always_comb begin
    pat_m = 3'b000;
    case (pattern_sel)
      2'd1:    pat_m = bar_m;
      2'd2:    pat_m = {3{h_q[3] ^ v_q[3]}};
      2'd3:    pat_m = 3'b111;
      default: pat_m = 3'b000;
    endcase
  end

  assign pat0 = {{COLOR_W{pat_m[2]}}, {COLOR_W{pat_m[1]}},
                 {COLOR_W{pat_m[0]}}};

  assign hx       = h_q >> SCALE_LOG2;
  assign vy       = v_q >> SCALE_LOG2;
  assign fb_x     = act0 ? 10'(hx) : 10'd0;
  assign fb_y     = act0 ? 9'(vy) : 9'd0;
  assign fb_rd_en = act0 && (pattern_sel == 2'd0);

  // Everything travels with the request so fb_rdata meets its own pixel.
  logic [DW-1:0] s0, sl;
  assign s0 = {act0, hs0, vs0, sof0, pattern_sel, pat0};

  generate
    if (FB_LATENCY == 0) begin : g_nodly
      assign sl = s0;
    end else begin : g_dly
      logic [DW-1:0] dl_q [FB_LATENCY];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < FB_LATENCY; i++) dl_q[i] <= '0;
        end else begin
          dl_q[0] <= s0;
          for (int i = 1; i < FB_LATENCY; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign sl = dl_q[FB_LATENCY-1];
    end
  endgenerate

  logic           sl_act, sl_hs, sl_vs, sl_sof;
  logic [1:0]     sl_psel;
  logic [CW3-1:0] sl_pat;
  assign {sl_act, sl_hs, sl_vs, sl_sof, sl_psel, sl_pat} = sl;

  logic           blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
  logic [CW3-1:0] rgb_q, rgb_d;

  always_comb begin
    blank_d = sl_act;
    hs_d    = sl_hs ? SYNC_POL : ~SYNC_POL;
    vs_d    = sl_vs ? SYNC_POL : ~SYNC_POL;
    sof_d   = sl_sof;
    rgb_d   = '0;
    if (sl_act) rgb_d = (sl_psel == 2'd0) ? fb_rdata : sl_pat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_q <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      sof_q   <= 1'b0;
      rgb_q   <= '0;
    end else begin
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      sof_q   <= sof_d;
      rgb_q   <= rgb_d;
    end
  end

  assign blank_n = blank_q;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign sof     = sof_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: scoreboard bench for vga_scan_engine.
// Small raster, 2-cycle framebuffer, 2x replication.
module tb_vga_scan_engine;

  localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 16, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = 48, VT = 23, FRAME = HT * VT;
  localparam int L = 2, S = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  psel = 2'd0;
  logic        fb_rd_en, hsync, vsync, blank_n, sof;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [23:0] fb_rdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [23:0] p1 = '0, p2 = '0;

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .SCALE_LOG2(S), .FB_LATENCY(L), .COLOR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(psel),
    .fb_rd_en(fb_rd_en), .fb_x(fb_x), .fb_y(fb_y),
    .fb_rdata(fb_rdata), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .sof(sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        sofv;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   mh = 0, mv = 0, xmax = 0, ymax = 0;
  bit   mrun = 1'b0;
  logic [2:0] bar_tbl [8] = '{3'd7, 3'd6, 3'd3, 3'd2,
                              3'd5, 3'd4, 3'd1, 3'd0};

  function automatic logic [23:0] fbval(input int x, input int y);
    return {8'(x), 8'(y), 8'(x * 3 + y)};
  endfunction

  function automatic logic [23:0] expand(input logic [2:0] m);
    return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Framebuffer with a two-stage read pipeline.
  always @(posedge clk) begin
    p1 <= fbval(int'(fb_x), int'(fb_y));
    p2 <= p1;
  end
  assign fb_rdata = p2;

  // Model: tracks the raster and queues the pixel each edge launches.
  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        mrun = 1'b0; mh = 0; mv = 0;
      end else if (!mrun) begin
        if (en) mrun = 1'b1;
      end else begin
        if (mh < HA && mv < VA) begin
          e.cyc  = cyc + L;
          e.sofv = (mh == 0 && mv == 0);
          case (psel)
            2'd0:    e.rgb = fbval(mh >> S, mv >> S);
            2'd1:    e.rgb = expand(bar_tbl[mh * 8 / HA]);
            2'd2:    e.rgb = expand({3{mh[3] ^ mv[3]}});
            default: e.rgb = 24'hFFFFFF;
          endcase
          sb.push_back(e);
        end
        if (mh == HT - 1) begin
          mh = 0;
          if (mv == VT - 1) begin
            mv = 0;
            if (!en) mrun = 1'b0;
          end else mv++;
        end else mh++;
      end
    end
  end

  // Monitor: pops one expected pixel whenever blank_n is high.
  initial begin : monitor
    exp_t e2;
    bit   act;
    int   ex, ey;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (blank_n) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL pixel_extra: blank_n at cycle %0d, none due", cyc);
          end else begin
            e2 = sb.pop_front();
            if (e2.cyc != cyc || e2.sofv != sof
                || e2.rgb != {vga_r, vga_g, vga_b}) begin
              errors++;
              $display("FAIL pixel: got cyc %0d sof %0b rgb %06h, want cyc %0d sof %0b rgb %06h",
                       cyc, sof, {vga_r, vga_g, vga_b}, e2.cyc, e2.sofv, e2.rgb);
            end
          end
        end else begin
          checks++;
          if ({vga_r, vga_g, vga_b} != 24'h0 || sof) begin
            errors++;
            $display("FAIL blank_out: rgb %06h sof %0b, want 0 0",
                     {vga_r, vga_g, vga_b}, sof);
          end
        end
        act = mrun && mh < HA && mv < VA;
        ex  = act ? (mh >> S) : 0;
        ey  = act ? (mv >> S) : 0;
        checks++;
        if (fb_rd_en != (act && psel == 2'd0)
            || int'(fb_x) != ex || int'(fb_y) != ey) begin
          errors++;
          $display("FAIL addr: rd %0b x %0d y %0d, want rd %0b x %0d y %0d",
                   fb_rd_en, fb_x, fb_y, act && psel == 2'd0, ex, ey);
        end
        if (fb_rd_en && int'(fb_x) > xmax) xmax = int'(fb_x);
        if (fb_rd_en && int'(fb_y) > ymax) ymax = int'(fb_y);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_sync"}, int'({hsync, vsync}), 3);
    chk({nm, "_ctl"}, int'({blank_n, sof, fb_rd_en}), 0);
    chk({nm, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_sync"}, int'({hsync, vsync}), 3);
    chk({nm, "_ctl"}, int'({blank_n, fb_rd_en}), 0);
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Measures one frame starting at a sof pulse.
  task automatic frame_stats(input string nm);
    int n, hs_lo, vs_lo, bl, sofs, hs_first, vs_first;
    n = 0; hs_lo = 0; vs_lo = 0; bl = 0; sofs = 0;
    hs_first = -1; vs_first = -1;
    @(negedge clk);
    while (!sof && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!sof) begin
      timeout({nm, "_sof"});
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
      if (blank_n) bl++;
      if (sof) sofs++;
      if (!hsync && hs_first < 0) hs_first = i;
      if (!vsync && vs_first < 0) vs_first = i;
      @(negedge clk);
    end
    chk({nm, "_hs_low"}, hs_lo, HSW * VT);
    chk({nm, "_vs_low"}, vs_lo, VSW * HT);
    chk({nm, "_visible"}, bl, HA * VA);
    chk({nm, "_sof_cnt"}, sofs, 1);
    chk({nm, "_hs_first"}, hs_first, HA + HFP);
    chk({nm, "_vs_first"}, vs_first, (VA + VFP) * HT);
    chk({nm, "_period"}, int'(sof), 1);
  endtask

  initial begin : stim
    int n;
    #1 rst = 1'b0;
    #1 chk_reset("reset_init");
    tick(3);
    chk_reset("reset_held");
    rst = 1'b1;
    tick(5);
    chk_idle("idle_en0");
    en = 1'b1;
    frame_stats("fb0");
    tick(1);
    psel = 2'd1; tick(FRAME);
    psel = 2'd2; tick(FRAME);
    psel = 2'd3; tick(300);
    psel = 2'd0; tick(400);

    n = 0;
    while (!(mv == 8 && mh == 10) && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    if (n >= 2 * FRAME) timeout("reach_mid");
    en = 1'b0;
    n = 0;
    while (mrun && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    if (mrun) timeout("frame_end");
    tick(L + 2);
    for (int i = 0; i < 20; i++) begin
      chk_idle("idle_after_drop");
      tick(1);
    end
    chk("sb_drain_idle", sb.size(), 0);

    en = 1'b1;
    frame_stats("reen");
    tick(1);
    n = 0;
    while (!(mv == 12 && mh == 20) && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    if (n >= 2 * FRAME) timeout("reach_rst_pt");
    rst = 1'b0;
    #1 chk_reset("reset_mid");
    sb.delete();
    tick(3);
    chk_reset("reset_mid_held");
    rst = 1'b1;
    frame_stats("after_rst");
    chk("fb_x_max", xmax, HA / 2 - 1);
    chk("fb_y_max", ymax, VA / 2 - 1);

    tick(1);
    en = 1'b0;
    n = 0;
    while (mrun && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    if (mrun) timeout("final_idle");
    tick(L + 3);
    chk("sb_drain_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
